// File: rtl/line_window_buffer.sv
// Ring of F image rows feeding zero-padded F-row windows to a convolution stage.
// Optional vertical stride 2 is enabled with `define LINE_BUF_STRIDE2_EN.
module line_window_buffer #(
    parameter int D         = 1,
    parameter int H         = 24,
    parameter int W         = 24,
    parameter int DATA_BITS = 8,
    parameter int F         = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [D*W*DATA_BITS-1:0]             row_i,
    input  logic                                 row_valid_i,
    output logic                                 row_ready_o,
    output logic [F*D*(W+F-1)*DATA_BITS-1:0]     win_o,
    output logic                                 win_valid_o,
    output logic [$clog2(H)-1:0]                 win_row_o,
    input  logic                                 consumer_done_i,
    output logic                                 frame_done_o,
    output logic [1:0]                           fsm_state_o
);
    localparam int P        = (F - 1) / 2;
    localparam int RW       = D * (W + 2 * P) * DATA_BITS;
    localparam int ROW_BITS = D * W * DATA_BITS;
    localparam int CNT_W    = $clog2(H + 1);
    localparam int ROW_W    = $clog2(H);
    localparam int SLOT_W   = $clog2(F);
`ifdef LINE_BUF_STRIDE2_EN
    localparam int STEP     = 2;
`else
    localparam int STEP     = 1;
`endif
    localparam int LAST_ROW = ((H - 1) / STEP) * STEP;

    // Handshakes: a row moves when row_valid_i && row_ready_o at a rising edge;
    // win_valid_o is a one-cycle start pulse, consumer_done_i is sampled only in S_WAIT.
    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    in_cnt, in_cnt_next, in_cnt_inc;
    logic [ROW_W-1:0]    out_row, out_row_next;
    logic [SLOT_W-1:0]   wr_ptr;
    logic                wr_en;
    logic                done_next;
    logic [ROW_BITS-1:0] ring [F];
    logic [F*RW-1:0]     win_next;
    logic [ROW_BITS-1:0] row_sel;
    logic [SLOT_W-1:0]   slot;
    int                  src;

    // Number of input rows that must be present before output row r can issue.
    function automatic logic [CNT_W-1:0] need_of(input int r);
        int n;
        n = r + P;
        if (n > H - 1) n = H - 1;
        return CNT_W'(n + 1);
    endfunction

    assign row_ready_o = (state == S_FILL) && (in_cnt < CNT_W'(H));
    assign win_valid_o = (state == S_ISSUE);
    assign fsm_state_o = state;
    assign in_cnt_inc  = in_cnt + CNT_W'(1);

    always_comb begin
        state_next   = state;
        in_cnt_next  = in_cnt;
        out_row_next = out_row;
        wr_en        = 1'b0;
        done_next    = 1'b0;
        case (state)
            S_FILL: begin
                if (row_valid_i && row_ready_o) begin
                    wr_en       = 1'b1;
                    in_cnt_next = in_cnt_inc;
                    if (in_cnt_inc == need_of(int'(out_row))) state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (consumer_done_i) begin
                    if (out_row == ROW_W'(LAST_ROW)) begin
                        done_next    = 1'b1;
                        in_cnt_next  = '0;
                        out_row_next = '0;
                        state_next   = S_FILL;
                    end else begin
                        out_row_next = out_row + ROW_W'(STEP);
                        if (in_cnt >= need_of(int'(out_row) + STEP)) state_next = S_ISSUE;
                        else state_next = S_FILL;
                    end
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    // The window is registered on entry to S_ISSUE, so a row accepted in that
    // same cycle is bypassed from row_i instead of read back from the ring.
    always_comb begin
        win_next = '0;
        src      = 0;
        slot     = '0;
        row_sel  = '0;
        for (int k = 0; k < F; k++) begin
            src = int'(out_row_next) - P + k;
            if (src >= 0 && src < H) begin
                slot    = SLOT_W'(src % F);
                row_sel = (wr_en && slot == wr_ptr) ? row_i : ring[slot];
                win_next[k*RW + P*D*DATA_BITS +: ROW_BITS] = row_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_FILL;
            in_cnt       <= '0;
            out_row      <= '0;
            wr_ptr       <= '0;
            win_o        <= '0;
            win_row_o    <= '0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_next;
            in_cnt       <= in_cnt_next;
            out_row      <= out_row_next;
            frame_done_o <= done_next;
            if (done_next) wr_ptr <= '0;
            else if (wr_en) wr_ptr <= (wr_ptr == SLOT_W'(F - 1)) ? '0 : wr_ptr + SLOT_W'(1);
            if (state_next == S_ISSUE) begin
                win_o     <= win_next;
                win_row_o <= out_row_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ring[wr_ptr] <= row_i;
    end
endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: 3-line frame, backpressure, flush,
// 5-line multi-channel frame, mid-frame reset, and stride-2 when LINE_BUF_STRIDE2_EN is set.
module tb_line_window_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int vectors = 0;
    int miscompares = 0;
    logic [559:0] exp_q[$];
    logic [559:0] expw;

    // instance A: D=1 H=4 W=4 F=3
    logic [31:0]  a_row;
    logic         a_valid, a_ready, a_wv, a_done, a_fd;
    logic [143:0] a_win;
    logic [1:0]   a_wrow, a_st;

    // instance B: D=2 H=6 W=3 F=5
    logic [47:0]  b_row;
    logic         b_valid, b_ready, b_wv, b_done, b_fd;
    logic [559:0] b_win;
    logic [2:0]   b_wrow;
    logic [1:0]   b_st;

    line_window_buffer #(.D(1), .H(4), .W(4), .DATA_BITS(8), .F(3)) dut_a (
        .clk(clk), .reset(reset), .row_i(a_row), .row_valid_i(a_valid),
        .row_ready_o(a_ready), .win_o(a_win), .win_valid_o(a_wv), .win_row_o(a_wrow),
        .consumer_done_i(a_done), .frame_done_o(a_fd), .fsm_state_o(a_st)
    );

    line_window_buffer #(.D(2), .H(6), .W(3), .DATA_BITS(8), .F(5)) dut_b (
        .clk(clk), .reset(reset), .row_i(b_row), .row_valid_i(b_valid),
        .row_ready_o(b_ready), .win_o(b_win), .win_valid_o(b_wv), .win_row_o(b_wrow),
        .consumer_done_i(b_done), .frame_done_o(b_fd), .fsm_state_o(b_st)
    );

`ifdef LINE_BUF_STRIDE2_EN
    logic [31:0]  c_row;
    logic         c_valid, c_ready, c_wv, c_done, c_fd;
    logic [143:0] c_win;
    logic [2:0]   c_wrow;
    logic [1:0]   c_st;
    int           c_pulses = 0;

    line_window_buffer #(.D(1), .H(5), .W(4), .DATA_BITS(8), .F(3)) dut_c (
        .clk(clk), .reset(reset), .row_i(c_row), .row_valid_i(c_valid),
        .row_ready_o(c_ready), .win_o(c_win), .win_valid_o(c_wv), .win_row_o(c_wrow),
        .consumer_done_i(c_done), .frame_done_o(c_fd), .fsm_state_o(c_st)
    );

    always @(posedge clk) if (c_wv) c_pulses++;
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [599:0] obs, input logic [599:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] row_a(input int v);
        return {4{8'(v)}};
    endfunction

    // padded 6-pixel row with value v in the four interior columns
    function automatic logic [47:0] prow_a(input int v);
        return {8'h00, {4{8'(v)}}, 8'h00};
    endfunction

    function automatic logic [7:0] val_b(input int r, input int x, input int d);
        return 8'(r * 16 + x * 2 + d + 1);
    endfunction

    function automatic logic [47:0] row_b(input int r);
        logic [47:0] v;
        v = '0;
        for (int x = 0; x < 3; x++)
            for (int d = 0; d < 2; d++)
                v[(x*2+d)*8 +: 8] = val_b(r, x, d);
        return v;
    endfunction

    function automatic logic [559:0] win_b(input int r);
        logic [559:0] w;
        int s;
        w = '0;
        for (int k = 0; k < 5; k++) begin
            s = r - 2 + k;
            if (s >= 0 && s < 6)
                for (int x = 0; x < 3; x++)
                    for (int d = 0; d < 2; d++)
                        w[k*112 + ((x+2)*2+d)*8 +: 8] = val_b(s, x, d);
        end
        return w;
    endfunction

    initial begin
        reset = 1'b1;
        a_row = '0; a_valid = 1'b0; a_done = 1'b0;
        b_row = '0; b_valid = 1'b0; b_done = 1'b0;
`ifdef LINE_BUF_STRIDE2_EN
        c_row = '0; c_valid = 1'b0; c_done = 1'b0;
`endif
        #2;
        check("rst_ready", a_ready, 1);
        check("rst_win_valid", a_wv, 0);
        check("rst_frame_done", a_fd, 0);
        check("rst_win", a_win, 0);
        check("rst_win_row", a_wrow, 0);
        check("rst_b_ready", b_ready, 1);
        tick; tick;
        reset = 1'b0;

`ifndef LINE_BUF_STRIDE2_EN
        // normal frame with backpressure on row 2
        a_valid = 1'b1; a_row = row_a(1); tick;
        check("a_row0_no_issue", a_wv, 0);
        a_row = row_a(2); tick;
        a_row = row_a(3);
        check("a_issue0_valid", a_wv, 1);
        check("a_issue0_row", a_wrow, 0);
        check("a_issue0_win", a_win, {prow_a(2), prow_a(1), 48'h0});
        check("a_issue0_ready", a_ready, 0);
        tick;
        check("a_wait_ready", a_ready, 0);
        check("a_wait_pulse_low", a_wv, 0);
        tick; tick;
        check("a_wait_ready_held", a_ready, 0);
        a_done = 1'b1; tick; a_done = 1'b0;
        check("a_fill_ready", a_ready, 1);
        check("a_fill_no_issue", a_wv, 0);
        tick;
        a_row = row_a(4);
        check("a_issue1_valid", a_wv, 1);
        check("a_issue1_row", a_wrow, 1);
        check("a_issue1_win", a_win, {prow_a(3), prow_a(2), prow_a(1)});
        tick;
        a_done = 1'b1; tick; a_done = 1'b0;
        tick;
        a_valid = 1'b0;
        check("a_issue2_valid", a_wv, 1);
        check("a_issue2_row", a_wrow, 2);
        check("a_issue2_win", a_win, {prow_a(4), prow_a(3), prow_a(2)});
        tick;
        a_done = 1'b1; tick; a_done = 1'b0;
        check("a_flush_valid", a_wv, 1);
        check("a_flush_row", a_wrow, 3);
        check("a_flush_win", a_win, {48'h0, prow_a(4), prow_a(3)});
        check("a_flush_ready", a_ready, 0);
        tick;
        a_done = 1'b1; tick; a_done = 1'b0;
        check("a_frame_done", a_fd, 1);
        check("a_frame_ready", a_ready, 1);
        check("a_frame_no_issue", a_wv, 0);
        tick;
        check("a_frame_done_clear", a_fd, 0);
        check("a_win_hold", a_win, {48'h0, prow_a(4), prow_a(3)});
        check("a_win_row_hold", a_wrow, 3);
        a_done = 1'b1; tick; a_done = 1'b0;
        check("a_done_in_fill_ignored", a_wv, 0);
        check("a_done_in_fill_no_frame", a_fd, 0);

        // reset while waiting on row 1
        a_valid = 1'b1;
        a_row = row_a(11); tick;
        a_row = row_a(12); tick;
        a_valid = 1'b0;
        check("a_r_issue0_row", a_wrow, 0);
        tick;
        a_done = 1'b1; tick; a_done = 1'b0;
        a_valid = 1'b1; a_row = row_a(13); tick;
        a_valid = 1'b0;
        check("a_r_issue1_row", a_wrow, 1);
        tick;
        #2; reset = 1'b1; #1;
        check("a_r_async_ready", a_ready, 1);
        check("a_r_async_win", a_win, 0);
        check("a_r_async_row", a_wrow, 0);
        check("a_r_async_valid", a_wv, 0);
        check("a_r_async_fd", a_fd, 0);
        tick;
        reset = 1'b0;
        a_valid = 1'b1;
        a_row = row_a(21); tick;
        a_row = row_a(22); tick;
        a_valid = 1'b0;
        check("a_r_new_valid", a_wv, 1);
        check("a_r_new_row", a_wrow, 0);
        check("a_r_new_win", a_win, {prow_a(22), prow_a(21), 48'h0});

        // multi-channel F=5 frame
        b_valid = 1'b1;
        for (int r = 0; r < 3; r++) begin
            b_row = row_b(r);
            tick;
            if (r < 2) check($sformatf("b_early_%0d", r), b_wv, 0);
        end
        b_valid = 1'b0;
        exp_q.push_back(win_b(0));
        check("b_issue0_valid", b_wv, 1);
        check("b_issue0_row", b_wrow, 0);
        expw = exp_q.pop_front();
        for (int k = 0; k < 5; k++)
            for (int x = 0; x < 7; x++)
                for (int d = 0; d < 2; d++) begin
                    int bp;
                    bp = k * 112 + (x * 2 + d) * 8;
                    check($sformatf("b_elem_k%0d_x%0d_d%0d", k, x, d), b_win[bp +: 8], expw[bp +: 8]);
                end
        for (int r = 1; r < 6; r++) begin
            tick;
            b_done = 1'b1; tick; b_done = 1'b0;
            if (r + 2 <= 5) begin
                check($sformatf("b_fill_ready_%0d", r), b_ready, 1);
                b_valid = 1'b1; b_row = row_b(r + 2); tick; b_valid = 1'b0;
            end
            exp_q.push_back(win_b(r));
            check($sformatf("b_issue%0d_valid", r), b_wv, 1);
            check($sformatf("b_issue%0d_row", r), b_wrow, r);
            expw = exp_q.pop_front();
            check($sformatf("b_issue%0d_win", r), b_win, expw);
        end
        tick;
        b_done = 1'b1; tick; b_done = 1'b0;
        check("b_frame_done", b_fd, 1);
        check("b_frame_ready", b_ready, 1);
`else
        // stride-2 frame, H=5: only rows 0, 2, 4 issue
        c_valid = 1'b1;
        c_row = row_a(1); tick;
        c_row = row_a(2); tick;
        c_valid = 1'b0;
        check("c_issue0_valid", c_wv, 1);
        check("c_issue0_row", c_wrow, 0);
        check("c_issue0_win", c_win, {prow_a(2), prow_a(1), 48'h0});
        tick;
        c_done = 1'b1; tick; c_done = 1'b0;
        check("c_fill_after0", c_ready, 1);
        c_valid = 1'b1;
        c_row = row_a(3); tick;
        check("c_odd_no_issue", c_wv, 0);
        c_row = row_a(4); tick;
        c_valid = 1'b0;
        check("c_issue2_valid", c_wv, 1);
        check("c_issue2_row", c_wrow, 2);
        check("c_issue2_win", c_win, {prow_a(4), prow_a(3), prow_a(2)});
        tick;
        c_done = 1'b1; tick; c_done = 1'b0;
        c_valid = 1'b1; c_row = row_a(5); tick; c_valid = 1'b0;
        check("c_issue4_valid", c_wv, 1);
        check("c_issue4_row", c_wrow, 4);
        check("c_issue4_win", c_win, {48'h0, prow_a(5), prow_a(4)});
        tick;
        c_done = 1'b1; tick; c_done = 1'b0;
        check("c_frame_done", c_fd, 1);
        check("c_frame_ready", c_ready, 1);
        tick; tick;
        check("c_pulse_count", c_pulses, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
